// File: rtl/pwm_capture.sv
// pwm_capture: synchronised, glitch-filtered PWM high-time and period meter.
// Publishes one measurement per complete rise-to-rise period.
module pwm_capture #(
  parameter int CNT_W    = 24,
  parameter int FILT_LEN = 3,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clk_100,
  input  logic             resetN,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

  localparam logic [3:0]       FL_MAX = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic             r_filt_d;
  logic [3:0]       r_flt_cnt;
  state_t           r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_period;
  logic             r_meas_valid;
  logic             r_timeout;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_per_nx;
  logic [CNT_W-1:0] w_hi_nx;
  logic             w_pub;
  logic             w_tmo;
  logic             w_rise;
  logic             w_fall;
  logic             w_tmo_hit;

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_filt    <= 1'b0;
      r_filt_d  <= 1'b0;
      r_flt_cnt <= '0;
    end else begin
      r_sync1  <= pwm_in;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      if (r_sync2 == r_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FL_MAX) begin
        r_filt    <= r_sync2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 4'd1;
      end
    end
  end

  assign w_rise    = r_filt & ~r_filt_d;
  assign w_fall    = ~r_filt & r_filt_d;
  assign w_tmo_hit = (r_per_cnt == TMO);

  // Timeout is checked before edges so a coincident edge is dropped.
  always_comb begin
    w_state_nx = r_state;
    w_per_nx   = r_per_cnt;
    w_hi_nx    = r_hi_cnt;
    w_pub      = 1'b0;
    w_tmo      = 1'b0;
    if (!enable) begin
      w_state_nx = ST_IDLE;
      w_per_nx   = '0;
      w_hi_nx    = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nx = ST_HIGH;
            w_per_nx   = ONE;
            w_hi_nx    = ONE;
          end
        end
        ST_HIGH: begin
          if (w_tmo_hit) begin
            w_state_nx = ST_IDLE;
            w_per_nx   = '0;
            w_hi_nx    = '0;
            w_tmo      = 1'b1;
          end else if (w_fall) begin
            w_state_nx = ST_LOW;
            w_per_nx   = r_per_cnt + ONE;
          end else begin
            w_per_nx   = r_per_cnt + ONE;
            w_hi_nx    = r_hi_cnt + ONE;
          end
        end
        ST_LOW: begin
          if (w_tmo_hit) begin
            w_state_nx = ST_IDLE;
            w_per_nx   = '0;
            w_hi_nx    = '0;
            w_tmo      = 1'b1;
          end else if (w_rise) begin
            w_state_nx = ST_HIGH;
            w_per_nx   = ONE;
            w_hi_nx    = ONE;
            w_pub      = 1'b1;
          end else begin
            w_per_nx   = r_per_cnt + ONE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_per_nx   = '0;
          w_hi_nx    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100 or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_high_time  <= '0;
      r_period     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_per_cnt    <= w_per_nx;
      r_hi_cnt     <= w_hi_nx;
      r_meas_valid <= w_pub;
      r_timeout    <= w_tmo;
      if (w_pub) begin
        r_high_time <= r_hi_cnt;
        r_period    <= r_per_cnt;
      end
    end
  end

  assign high_time  = r_high_time;
  assign period     = r_period;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;
  assign level      = r_filt;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven and randomized checks of pwm_capture
// against expectations derived from the generated waveform phases.
module tb_pwm_capture;

  localparam int CNT_W    = 24;
  localparam int FILT_LEN = 3;
  localparam int TIMEOUT  = 2000;
  localparam int LAT      = 2 + FILT_LEN + 1;

  logic             clk_100 = 1'b0;
  logic             resetN  = 1'b1;
  logic             enable  = 1'b0;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             timeout;
  logic             level;

  pwm_capture #(
    .CNT_W   (CNT_W),
    .FILT_LEN(FILT_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_100   (clk_100),
    .resetN    (resetN),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  typedef struct {
    int h;
    int p;
    int gap;
  } exp_t;

  typedef struct {
    int h;
    int l;
    int gh;
    int gl;
    int exp_h;
    int exp_p;
    bit rep;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   mv_n      = 0;
  int   tmo_n     = 0;
  int   tmo_cyc   = 0;
  int   last_mv   = 0;
  int   lvl_rises = 0;
  logic lvl_q     = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int h, input int p, input int gap);
    exp_t e;
    e.h   = h;
    e.p   = p;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk_100);
    if (level === 1'b1 && lvl_q === 1'b0) lvl_rises++;
    lvl_q = level;
    if (meas_valid && timeout) check("mv_tmo_exclusive", 1, 0);
    if (timeout) begin
      tmo_n++;
      tmo_cyc = cyc;
    end
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: high_time=%0d period=%0d, want none",
                 high_time, period);
      end else begin
        e = exp_q.pop_front();
        check("high_time", high_time, e.h);
        check("period", period, e.p);
        if (e.gap != 0) check("strobe_gap", cyc - last_mv, e.gap);
      end
      mv_n++;
      last_mv = cyc;
    end
  endtask

  task automatic phase(input logic v, input int n);
    pwm_in = v;
    repeat (n) tick();
  endtask

  task automatic half(input logic v, input int n, input int g);
    int a;
    if (g > 0) begin
      a = (n - g) / 2;
      phase(v, a);
      phase(~v, g);
      phase(v, n - a - g);
    end else begin
      phase(v, n);
    end
  endtask

  task automatic pulse(input int h, input int l, input int gh, input int gl);
    half(1'b1, h, gh);
    half(1'b0, l, gl);
  endtask

  initial begin
    vec_t tbl[9];
    int   mv0;
    int   t0;
    int   d;
    int   h;
    int   l;
    int   gh;
    int   gl;

    tbl[0] = '{50, 150, 0, 0, 50, 200, 1'b1};
    tbl[1] = '{50, 150, 0, 0, 50, 200, 1'b1};
    tbl[2] = '{50, 150, 0, 2, 50, 200, 1'b1};
    tbl[3] = '{50, 150, 1, 0, 50, 200, 1'b1};
    tbl[4] = '{120, 80, 0, 0, 120, 200, 1'b1};
    tbl[5] = '{120, 80, 0, 0, 120, 200, 1'b1};
    tbl[6] = '{3, 3, 0, 0, 3, 6, 1'b1};
    tbl[7] = '{7, 4, 0, 0, 7, 11, 1'b1};
    tbl[8] = '{50, 150, 0, 0, 0, 0, 1'b0};

    #1 resetN = 1'b0;
    repeat (3) tick();
    check("rst_high_time", high_time, 0);
    check("rst_period", period, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_level", level, 0);
    resetN = 1'b1;
    enable = 1'b1;
    phase(1'b0, 20);

    for (int i = 0; i < 9; i++) begin
      pulse(tbl[i].h, tbl[i].l, tbl[i].gh, tbl[i].gl);
      if (tbl[i].rep) begin
        if (i > 0) push_exp(tbl[i].exp_h, tbl[i].exp_p, tbl[i].h + tbl[i].l);
        else push_exp(tbl[i].exp_h, tbl[i].exp_p, 0);
      end
    end
    check("table_drained", exp_q.size(), 0);
    check("table_strobes", mv_n, 8);
    check("table_level_rises", lvl_rises, 9);

    enable = 1'b0;
    phase(1'b0, 10);
    enable = 1'b1;
    phase(1'b0, 10);
    mv0 = mv_n;
    t0  = tmo_n;
    d   = cyc;
    phase(1'b1, TIMEOUT + 100);
    check("timeout_count", tmo_n - t0, 1);
    check("timeout_time", tmo_cyc - d, LAT + TIMEOUT);
    check("timeout_no_mv", mv_n - mv0, 0);
    check("timeout_hold_high", high_time, 7);
    check("timeout_hold_period", period, 11);
    phase(1'b0, 150);
    pulse(50, 150, 0, 0);
    push_exp(50, 200, 0);
    pulse(50, 150, 0, 0);
    push_exp(50, 200, 200);

    phase(1'b1, 50);
    phase(1'b0, 60);
    check("post_timeout_drained", exp_q.size(), 0);
    mv0 = mv_n;
    t0  = tmo_n;
    enable = 1'b0;
    phase(1'b0, 90);
    pulse(50, 150, 0, 0);
    phase(1'b0, 10);
    check("enable_low_no_mv", mv_n - mv0, 0);
    check("enable_low_no_tmo", tmo_n - t0, 0);
    enable = 1'b1;
    phase(1'b0, 20);
    pulse(50, 150, 0, 0);
    push_exp(50, 200, 0);
    pulse(90, 110, 0, 0);
    push_exp(90, 200, 200);
    pulse(50, 150, 0, 0);
    check("enable_drained", exp_q.size(), 0);

    phase(1'b0, 20);
    check("pre_reset_high_time", high_time, 90);
    @(posedge clk_100);
    #3 resetN = 1'b0;
    #1;
    check("async_rst_high_time", high_time, 0);
    check("async_rst_period", period, 0);
    check("async_rst_meas_valid", meas_valid, 0);
    check("async_rst_timeout", timeout, 0);
    check("async_rst_level", level, 0);
    repeat (3) tick();
    #2 resetN = 1'b1;
    mv0 = mv_n;
    phase(1'b0, 20);
    check("reset_release_no_mv", mv_n - mv0, 0);
    pulse(50, 150, 0, 0);
    push_exp(50, 200, 0);
    pulse(40, 160, 0, 0);
    push_exp(40, 200, 200);
    pulse(50, 150, 0, 0);
    check("reset_drained", exp_q.size(), 0);

    enable = 1'b0;
    phase(1'b0, 10);
    enable = 1'b1;
    phase(1'b0, 10);
    mv0 = mv_n;
    for (int i = 0; i < 24; i++) begin
      h  = int'($urandom_range(FILT_LEN, 250));
      l  = int'($urandom_range(FILT_LEN, 250));
      gh = 0;
      gl = 0;
      if (h >= 20 && $urandom_range(0, 2) == 0)
        gh = int'($urandom_range(1, FILT_LEN - 1));
      if (l >= 20 && $urandom_range(0, 2) == 0)
        gl = int'($urandom_range(1, FILT_LEN - 1));
      pulse(h, l, gh, gl);
      if (i < 23) push_exp(h, h + l, (i > 0) ? h + l : 0);
    end
    phase(1'b0, 30);
    check("random_drained", exp_q.size(), 0);
    check("random_strobes", mv_n - mv0, 23);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
